// File: rtl/sram_mem_controller_pkg.sv
// Memory-interface constants and state encoding shared by the SRAM controller and its users.
package sram_mem_controller_pkg;

    localparam logic [31:0] BASE_ADDR = 32'd1024;
    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned SRAM_DW   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Word index of a byte address relative to the SRAM window, with 32-bit wrap.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_controller.sv
// Splits a 32-bit pipeline load/store into two sequenced 16-bit asynchronous SRAM
// accesses (low half, then high half) and freezes the pipeline while they run.
//
// state | meaning
// IDLE  | bus parked, waiting for rd_en/wr_en
// LOW   | low half (sram_addr LSB=0) on the bus for HALF_CYCLES cycles
// HIGH  | high half (sram_addr LSB=1) on the bus for HALF_CYCLES cycles
// DONE  | bus parked, read_data valid, ready=1 for one cycle
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = sram_mem_controller_pkg::BASE_ADDR,
    parameter int unsigned HALF_CYCLES = 2,
    parameter int unsigned SRAM_AW     = sram_mem_controller_pkg::SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned      CW       = $clog2(HALF_CYCLES);
    localparam logic [CW-1:0]    LAST_CNT = CW'(HALF_CYCLES - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 op_write;
    logic [SRAM_AW-2:0]   word_addr;
    logic [SRAM_DW-1:0]   wdata_hi;
    logic [SRAM_AW-2:0]   req_word;
    logic                 last;

    assign req_word = (SRAM_AW-1)'(word_index(address, BASE_ADDR));
    assign last     = (cnt == LAST_CNT);

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~(rd_en | wr_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Bus outputs are registered one step ahead: each transition loads the values
    // the next cycle must present, so the SRAM pins never glitch between halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            read_data   <= '0;
            op_write    <= 1'b0;
            word_addr   <= '0;
            wdata_hi    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en | wr_en) begin
                        state       <= LOW;
                        cnt         <= '0;
                        op_write    <= wr_en;
                        word_addr   <= req_word;
                        wdata_hi    <= write_data[31:16];
                        sram_addr   <= {req_word, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : '0;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                        sram_oe_n   <= wr_en;
                        sram_ce_n   <= 1'b0;
                        sram_ub_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                    end
                end
                LOW: begin
                    if (last) begin
                        if (!op_write) read_data[15:0] <= sram_dq_in;
                        state       <= HIGH;
                        cnt         <= '0;
                        sram_addr   <= {word_addr, 1'b1};
                        sram_dq_out <= op_write ? wdata_hi : '0;
                        sram_we_n   <= ~op_write;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        sram_we_n <= ~op_write | (cnt + CW'(1) == LAST_CNT);
                    end
                end
                HIGH: begin
                    if (last) begin
                        if (!op_write) read_data[31:16] <= sram_dq_in;
                        state       <= DONE;
                        cnt         <= '0;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_ce_n   <= 1'b1;
                        sram_ub_n   <= 1'b1;
                        sram_lb_n   <= 1'b1;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        sram_we_n <= ~op_write | (cnt + CW'(1) == LAST_CNT);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
